// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_pkg
// Description : Shared types and helpers for the clkdiv_gen clock generator.
//               Holds the lock state encoding, the per-channel configuration
//               record and the divide-ratio clamp used by every channel.
// Revision    : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    // Smallest divide ratio a channel will actually run at.
    localparam int MIN_DIV = 2;

    // Width of the configuration record fields. Channels use the low DIV_W
    // bits; DIV_W must not exceed this.
    localparam int c_div_w_max = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_LOCKED = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic [c_div_w_max-1:0] div;
        logic [c_div_w_max-1:0] phase;
    } chan_cfg_t;

    // Ratios of 0 and 1 cannot produce a clock, so they run as MIN_DIV.
    function automatic logic [c_div_w_max-1:0] clamp_div(input logic [c_div_w_max-1:0] div_in);
        return (div_in < c_div_w_max'(MIN_DIV)) ? c_div_w_max'(MIN_DIV) : div_in;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_chan.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_chan
// Description : One divider channel. A modulo-div counter drives a registered
//               divided clock (high while cnt < div/2) and a one-cycle tick on
//               the last count of each period. Accepts config applies and
//               one-cycle phase steps (retard = hold, advance = +2 mod div).
//               With CLKDIV_GLITCHFREE_EN defined, a config is held pending
//               and only applied on the channel's wrap cycle.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n       reference clock, async active-low reset
//               i_standby        freeze: cnt=0, outputs low, drop pending
//               i_apply, i_cfg   config for this channel (div, start phase)
//               i_step, i_dir    phase step for this channel, 1 = retard
//               o_pending        config waiting for wrap (macro builds only)
//               o_applied        config applied this cycle (macro builds only)
//               o_clk, o_tick    registered divided clock and period strobe
// ============================================================================
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_standby,
    input  logic      i_apply,
    input  logic      i_step,
    input  logic      i_dir,
    input  chan_cfg_t i_cfg,
`ifdef CLKDIV_GLITCHFREE_EN
    output logic      o_pending,
    output logic      o_applied,
`endif
    output logic      o_clk,
    output logic      o_tick
);

    logic [DIV_W-1:0]       r_cnt;
    logic [DIV_W-1:0]       r_div;
    logic                   r_clk;
    logic                   r_tick;

    logic                   w_wrap;
    logic                   w_do_apply;
    chan_cfg_t              w_src;
    logic [c_div_w_max-1:0] w_new_div_full;
    logic [DIV_W-1:0]       w_new_div;
    logic [DIV_W-1:0]       w_new_cnt;
    logic [DIV_W-1:0]       w_adv_cnt;

    assign w_wrap = (r_cnt == r_div - DIV_W'(1));

`ifdef CLKDIV_GLITCHFREE_EN
    logic      r_pend;
    chan_cfg_t r_pend_cfg;

    // A fresh request landing exactly on the wrap cycle is applied at once;
    // anything else waits in r_pend for the next wrap.
    assign w_src      = r_pend ? r_pend_cfg : i_cfg;
    assign w_do_apply = (i_apply | r_pend) & w_wrap & ~i_standby;
    assign o_pending  = r_pend;
    assign o_applied  = w_do_apply;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_pend_cfg <= '0;
        end else if (i_standby) begin
            r_pend <= 1'b0;
        end else if (w_do_apply) begin
            r_pend <= 1'b0;
        end else if (i_apply) begin
            r_pend     <= 1'b1;
            r_pend_cfg <= i_cfg;
        end
    end
`else
    assign w_src      = i_cfg;
    assign w_do_apply = i_apply & ~i_standby;
`endif

    // Range checks run at full record width so an oversized phase is never
    // mistaken for a small one after truncation.
    assign w_new_div_full = clamp_div(w_src.div);
    assign w_new_div      = DIV_W'(w_new_div_full);
    assign w_new_cnt      = (w_src.phase < w_new_div_full) ? DIV_W'(w_src.phase) : '0;

    // Advance by two with wrap; div >= 2 so div-2 never underflows.
    assign w_adv_cnt = (r_cnt >= r_div - DIV_W'(2)) ? (r_cnt - (r_div - DIV_W'(2)))
                                                    : (r_cnt + DIV_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_div  <= DIV_W'(DEFAULT_DIV);
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (i_standby) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_clk  <= (r_cnt < (r_div >> 1));
            r_tick <= w_wrap;
            if (w_do_apply) begin
                // Config takes priority over a step in the same cycle.
                r_div <= w_new_div;
                r_cnt <= w_new_cnt;
            end else if (i_step) begin
                if (!i_dir) begin
                    r_cnt <= w_adv_cnt;
                end
            end else if (w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/clkdiv_gen.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_gen
// Description : Multi-channel clock generator. Derives NUM_CH divided clocks
//               and tick strobes from clk_i. Per-channel divide ratio and
//               start phase are loaded through a valid/ready config port;
//               channels can be stepped one cycle early/late. A lock FSM
//               reports locked_o after LOCK_CYCLES stable cycles.
//               Optional macro CLKDIV_GLITCHFREE_EN: configs are applied only
//               on the target channel's wrap cycle, ready is held low while
//               one is pending, and the lock FSM restarts at apply time.
// Revision    : 1.0 - initial release
// Ports       : clk_i, rst_ni           reference clock, async active-low reset
//               standby_i               freeze all channels, outputs low
//               cfg_valid_i/cfg_ready_o config handshake
//               cfg_ch_i, cfg_div_i, cfg_phase_i  target channel, ratio, phase
//               phasestep_i, phasesel_i, phasedir_i  step request (1 = retard)
//               clk_o, tick_o           registered divided clocks and strobes
//               locked_o                outputs stable
// ============================================================================
module clkdiv_gen
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16,
    localparam int c_ch_w     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int c_settle_w = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              standby_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [c_ch_w-1:0] cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic [DIV_W-1:0]  cfg_phase_i,
    input  logic              phasestep_i,
    input  logic [c_ch_w-1:0] phasesel_i,
    input  logic              phasedir_i,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic              locked_o
);

    logic                  w_cfg_fire;
    logic                  w_restart;

    logic                  r_apply;
    logic [c_ch_w-1:0]     r_cfg_ch;
    chan_cfg_t             r_cfg;
    logic                  r_step;
    logic [c_ch_w-1:0]     r_step_sel;
    logic                  r_step_dir;

    lock_state_e           r_state;
    logic [c_settle_w-1:0] r_settle;

    assign w_cfg_fire = cfg_valid_i & cfg_ready_o;

`ifdef CLKDIV_GLITCHFREE_EN
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_applied;

    // The in-flight r_apply cycle also counts as pending so a second request
    // cannot overwrite r_cfg before the channel has captured it.
    assign cfg_ready_o = ~standby_i & ~r_apply & ~(|w_pending);
    assign w_restart   = |w_applied;
`else
    assign cfg_ready_o = ~standby_i;
    assign w_restart   = w_cfg_fire;
`endif

    // Accepted configs and step requests are registered here and act on the
    // channels one cycle later. Out-of-range channel numbers match no channel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_apply    <= 1'b0;
            r_cfg_ch   <= '0;
            r_cfg      <= '0;
            r_step     <= 1'b0;
            r_step_sel <= '0;
            r_step_dir <= 1'b0;
        end else begin
            r_apply    <= w_cfg_fire;
            r_step     <= phasestep_i & ~standby_i;
            r_step_sel <= phasesel_i;
            r_step_dir <= phasedir_i;
            if (w_cfg_fire) begin
                r_cfg_ch <= cfg_ch_i;
                r_cfg    <= '{div: c_div_w_max'(cfg_div_i), phase: c_div_w_max'(cfg_phase_i)};
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        clkdiv_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk       (clk_i),
            .rst_n     (rst_ni),
            .i_standby (standby_i),
            .i_apply   (r_apply && (r_cfg_ch == c_ch_w'(c))),
            .i_step    (r_step && (r_step_sel == c_ch_w'(c))),
            .i_dir     (r_step_dir),
            .i_cfg     (r_cfg),
`ifdef CLKDIV_GLITCHFREE_EN
            .o_pending (w_pending[c]),
            .o_applied (w_applied[c]),
`endif
            .o_clk     (clk_o[c]),
            .o_tick    (tick_o[c])
        );
    end

    // Lock FSM. Phase steps deliberately do not feed w_restart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_settle <= '0;
        end else if (standby_i) begin
            r_state  <= S_IDLE;
            r_settle <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state  <= S_SETTLE;
                    r_settle <= '0;
                end
                S_SETTLE: begin
                    if (w_restart) begin
                        r_settle <= '0;
                    end else if (r_settle == c_settle_w'(LOCK_CYCLES - 1)) begin
                        r_state <= S_LOCKED;
                    end else begin
                        r_settle <= r_settle + c_settle_w'(1);
                    end
                end
                S_LOCKED: begin
                    if (w_restart) begin
                        r_state  <= S_SETTLE;
                        r_settle <= '0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_settle <= '0;
                end
            endcase
        end
    end

    assign locked_o = (r_state == S_LOCKED);

endmodule
`default_nettype wire
